// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transfer arbiter.
// Used by spi_xfer_arbiter and spi_arb_rr.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD,
        RELEASE
    } state_t;

    localparam int START_WAIT_DEF = 80;
    localparam int LOCK_LIMIT     = 16;

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Requester, engine and chip-select signals of the SPI transfer arbiter.
// slave = arbiter side, master = requesters/engine side.
interface spi_xfer_arbiter_if #(
    parameter int NSEL = 2
);
    logic            req0;
    logic            req1;
    logic            lock0;
    logic            lock1;
    logic [7:0]      txdata0;
    logic [7:0]      txdata1;
    logic            slow0;
    logic            slow1;
    logic [NSEL-1:0] ssel0;
    logic [NSEL-1:0] ssel1;
    logic            gnt0;
    logic            gnt1;
    logic            done0;
    logic            done1;
    logic [7:0]      rxdata;
    logic [7:0]      eng_txdata;
    logic            eng_txstart;
    logic            eng_slow;
    logic            eng_busy;
    logic [7:0]      eng_rxdata;
    logic [NSEL-1:0] spi_ssel_n;
    logic            err;

    modport slave (
        input  req0, req1, lock0, lock1,
        input  txdata0, txdata1, slow0, slow1,
        input  ssel0, ssel1, eng_busy, eng_rxdata,
        output gnt0, gnt1, done0, done1, rxdata,
        output eng_txdata, eng_txstart, eng_slow,
        output spi_ssel_n, err
    );

    modport master (
        output req0, req1, lock0, lock1,
        output txdata0, txdata1, slow0, slow1,
        output ssel0, ssel1, eng_busy, eng_rxdata,
        input  gnt0, gnt1, done0, done1, rxdata,
        input  eng_txdata, eng_txstart, eng_slow,
        input  spi_ssel_n, err
    );

endinterface

// File: rtl/spi_arb_rr.sv
// Two-way round-robin picker: on a tie the port that did not win last
// time is granted. last = index of the previous winner.
module spi_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (req[0] && (!req[1] || last)):  gnt = 2'b01;
            (req[1] && (!req[0] || !last)): gnt = 2'b10;
            default:                        gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI byte engine between the CPU port (0) and loader port (1).
// Define SPI_ARB_FAIRLOCK_EN to force-release a locked owner after 16 bytes.
module spi_xfer_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NSEL       = 2,
    parameter int START_WAIT = START_WAIT_DEF
) (
    input logic               clk,
    input logic               rst_n,
    spi_xfer_arbiter_if.slave bus
);

    localparam int CW = $clog2(START_WAIT + 1);

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      done_q, done_d;
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      tx_q, tx_d;
    logic            txs_q, txs_d;
    logic            slow_q, slow_d;
    logic            err_q, err_d;
    logic [NSEL-1:0] ssn_q, ssn_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            go_rel;
    logic            rel_ok;
    logic [1:0]      pick;
    logic            own_req;
    logic            own_lock;
    logic [7:0]      own_tx;

`ifdef SPI_ARB_FAIRLOCK_EN
    logic [4:0]      lcnt_q, lcnt_d;
    logic            oth_req;
    assign oth_req = owner_q ? bus.req0 : bus.req1;
`endif

    spi_arb_rr u_rr (
        .req  ({bus.req1, bus.req0}),
        .last (last_q),
        .gnt  (pick)
    );

    assign own_req  = owner_q ? bus.req1    : bus.req0;
    assign own_lock = owner_q ? bus.lock1   : bus.lock0;
    assign own_tx   = owner_q ? bus.txdata1 : bus.txdata0;

    // Release decision taken on the done cycle while in HOLD.
`ifdef SPI_ARB_FAIRLOCK_EN
    assign rel_ok = !own_lock ||
                    ((lcnt_q == 5'(LOCK_LIMIT)) && oth_req);
`else
    assign rel_ok = !own_lock;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        rx_d    = rx_q;
        tx_d    = tx_q;
        txs_d   = 1'b0;
        slow_d  = slow_q;
        err_d   = err_q;
        ssn_d   = ssn_q;
        cnt_d   = cnt_q;
        go_rel  = 1'b0;
`ifdef SPI_ARB_FAIRLOCK_EN
        lcnt_d  = lcnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) state_d = ARB;
            end
            ARB: begin
                if (pick == 2'b00) begin
                    state_d = IDLE;
                end else begin
                    owner_d = pick[1];
                    gnt_d   = pick;
                    tx_d    = pick[1] ? bus.txdata1 : bus.txdata0;
                    slow_d  = pick[1] ? bus.slow1 : bus.slow0;
                    ssn_d   = ~(pick[1] ? bus.ssel1 : bus.ssel0);
                    txs_d   = 1'b1;
                    state_d = START;
`ifdef SPI_ARB_FAIRLOCK_EN
                    lcnt_d  = '0;
`endif
                end
            end
            START: begin
                err_d   = 1'b0;
                cnt_d   = CW'(START_WAIT - 1);
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.eng_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == '0) begin
                    err_d  = 1'b1;
                    done_d = owner_q ? 2'b10 : 2'b01;
                    go_rel = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.eng_busy) begin
                    rx_d    = bus.eng_rxdata;
                    done_d  = owner_q ? 2'b10 : 2'b01;
                    state_d = HOLD;
`ifdef SPI_ARB_FAIRLOCK_EN
                    if (lcnt_q != 5'(LOCK_LIMIT))
                        lcnt_d = lcnt_q + 1'b1;
`endif
                end
            end
            HOLD: begin
                if (done_q != 2'b00) begin
                    go_rel = rel_ok;
                end else if (own_req) begin
                    tx_d    = own_tx;
                    txs_d   = 1'b1;
                    state_d = START;
                end else if (!own_lock) begin
                    go_rel = 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (go_rel) begin
            state_d = RELEASE;
            gnt_d   = 2'b00;
            ssn_d   = '1;
            last_d  = owner_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            rx_q    <= '0;
            tx_q    <= '0;
            txs_q   <= 1'b0;
            slow_q  <= 1'b0;
            err_q   <= 1'b0;
            ssn_q   <= '1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            txs_q   <= txs_d;
            slow_q  <= slow_d;
            err_q   <= err_d;
            ssn_q   <= ssn_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SPI_ARB_FAIRLOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lcnt_q <= '0;
        else        lcnt_q <= lcnt_d;
    end
`endif

    assign bus.gnt0        = gnt_q[0];
    assign bus.gnt1        = gnt_q[1];
    assign bus.done0       = done_q[0];
    assign bus.done1       = done_q[1];
    assign bus.rxdata      = rx_q;
    assign bus.eng_txdata  = tx_q;
    assign bus.eng_txstart = txs_q;
    assign bus.eng_slow    = slow_q;
    assign bus.spi_ssel_n  = ssn_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a behavioural SPI engine model.
module tb_spi_xfer_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_xfer_arbiter_if #(.NSEL(2)) bus ();

    spi_xfer_arbiter #(.NSEL(2), .START_WAIT(80)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Engine model: busy rises eng_delay+1 cycles after txstart, lasts eng_len+1
    int         eng_delay = 2;
    int         eng_len = 3;
    bit         eng_never = 1'b0;
    logic [7:0] eng_rx = 8'h00;
    logic       busy_m;
    bit         pend;
    int         dcnt, bcnt;

    assign bus.eng_busy   = busy_m;
    assign bus.eng_rxdata = eng_rx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_m <= 1'b0;
            pend   <= 1'b0;
            dcnt   <= 0;
            bcnt   <= 0;
        end else if (bus.eng_txstart && !eng_never) begin
            pend <= 1'b1;
            dcnt <= eng_delay;
        end else if (pend) begin
            if (dcnt == 0) begin
                pend   <= 1'b0;
                busy_m <= 1'b1;
                bcnt   <= eng_len;
            end else begin
                dcnt <= dcnt - 1;
            end
        end else if (busy_m) begin
            if (bcnt == 0) busy_m <= 1'b0;
            else           bcnt <= bcnt - 1;
        end
    end

    // Monitors
    int         txs_cnt = 0, d0_cnt = 0, d1_cnt = 0, dbl = 0;
    int         gap_bad = 0, ovl = 0, lk_hi = 0;
    bit         p1_active = 1'b0;
    logic       pd0 = 1'b0, pd1 = 1'b0;
    logic [1:0] prev_ssn = 2'b11;
    int         order[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ssn <= 2'b11;
            pd0 <= 1'b0;
            pd1 <= 1'b0;
        end else begin
            if (bus.eng_txstart) txs_cnt <= txs_cnt + 1;
            if (bus.done0) begin
                d0_cnt <= d0_cnt + 1;
                order.push_back(0);
            end
            if (bus.done1) begin
                d1_cnt <= d1_cnt + 1;
                order.push_back(1);
            end
            if ((bus.done0 && pd0) || (bus.done1 && pd1)) dbl <= dbl + 1;
            pd0 <= bus.done0;
            pd1 <= bus.done1;
            if (prev_ssn != 2'b11 && bus.spi_ssel_n != 2'b11 &&
                bus.spi_ssel_n != prev_ssn)
                gap_bad <= gap_bad + 1;
            prev_ssn <= bus.spi_ssel_n;
            if (p1_active && bus.gnt0) ovl <= ovl + 1;
            if (p1_active && bus.gnt1 && bus.spi_ssel_n == 2'b11)
                lk_hi <= lk_hi + 1;
        end
    end

    task automatic drive(int p, bit r, bit lk, logic [7:0] d,
                         bit sl, logic [1:0] ss);
        if (p == 0) begin
            bus.req0 = r; bus.lock0 = lk; bus.txdata0 = d;
            bus.slow0 = sl; bus.ssel0 = ss;
        end else begin
            bus.req1 = r; bus.lock1 = lk; bus.txdata1 = d;
            bus.slow1 = sl; bus.ssel1 = ss;
        end
    endtask

    // Returns #1 after the edge that ends the done cycle.
    task automatic wait_done(int p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((p == 0) ? bus.done0 : bus.done1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 8'h00, 0, 2'b00);
        drive(1, 0, 0, 8'h00, 0, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         port;
        logic [7:0] tx;
        bit         slow;
        logic [1:0] ssel;
        logic [7:0] rx;
        logic [1:0] exp_ssn;
    } vec_t;

    vec_t vecs[4];

    initial begin
        bit ok;
        int t0, dn0, lat;

        vecs[0] = '{0, 8'hA5, 1'b0, 2'b01, 8'h3C, 2'b10};
        vecs[1] = '{1, 8'h5A, 1'b1, 2'b10, 8'hC3, 2'b01};
        vecs[2] = '{0, 8'h00, 1'b1, 2'b10, 8'hFF, 2'b01};
        vecs[3] = '{1, 8'hFF, 1'b0, 2'b01, 8'h00, 2'b10};

        drive(0, 0, 0, 8'h00, 0, 2'b00);
        drive(1, 0, 0, 8'h00, 0, 2'b00);
        repeat (3) @(negedge clk);
        chk("rst_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
        chk("rst_done", {bus.done1, bus.done0}, 2'b00);
        chk("rst_rxdata", bus.rxdata, 8'h00);
        chk("rst_txdata", bus.eng_txdata, 8'h00);
        chk("rst_txstart_slow", {bus.eng_txstart, bus.eng_slow}, 2'b00);
        chk("rst_ssel_n", bus.spi_ssel_n, 2'b11);
        chk("rst_err", bus.err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single bytes from a vector table
        foreach (vecs[k]) begin
            eng_rx = vecs[k].rx;
            t0 = txs_cnt;
            dn0 = (vecs[k].port == 0) ? d0_cnt : d1_cnt;
            drive(vecs[k].port, 1, 0, vecs[k].tx, vecs[k].slow, vecs[k].ssel);
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (busy_m) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("v_busy_seen", ok, 1'b1);
            chk("v_ssel_n", bus.spi_ssel_n, vecs[k].exp_ssn);
            chk("v_txdata", bus.eng_txdata, vecs[k].tx);
            chk("v_slow", bus.eng_slow, vecs[k].slow);
            chk("v_gnt", {bus.gnt1, bus.gnt0},
                (vecs[k].port == 0) ? 2'b01 : 2'b10);
            wait_done(vecs[k].port, ok);
            chk("v_done_seen", ok, 1'b1);
            chk("v_rxdata", bus.rxdata, vecs[k].rx);
            drive(vecs[k].port, 0, 0, 8'h00, 0, 2'b00);
            repeat (3) @(negedge clk);
            #1;
            chk("v_ssel_after", bus.spi_ssel_n, 2'b11);
            chk("v_gnt_after", {bus.gnt1, bus.gnt0}, 2'b00);
            chk("v_txstart_cnt", txs_cnt - t0, 1);
            chk("v_done_cnt",
                ((vecs[k].port == 0) ? d0_cnt : d1_cnt) - dn0, 1);
        end
        chk("done_width", dbl, 0);

        // Round robin from reset: 0,1,0,1
        do_reset();
        order.delete();
        fork
            begin
                bit ok0;
                drive(0, 1, 0, 8'h10, 0, 2'b01);
                wait_done(0, ok0);
                drive(0, 1, 0, 8'h12, 0, 2'b01);
                wait_done(0, ok0);
                drive(0, 0, 0, 8'h00, 0, 2'b00);
            end
            begin
                bit ok1;
                drive(1, 1, 0, 8'h20, 0, 2'b10);
                wait_done(1, ok1);
                drive(1, 1, 0, 8'h22, 0, 2'b10);
                wait_done(1, ok1);
                drive(1, 0, 0, 8'h00, 0, 2'b00);
            end
        join
        repeat (2) @(negedge clk);
        chk("rr_count", order.size(), 4);
        if (order.size() == 4) begin
            chk("rr_seq", {order[0][1:0], order[1][1:0],
                           order[2][1:0], order[3][1:0]}, 8'b00_01_00_01);
        end

        // Port 1 locked for three bytes with port 0 waiting
        do_reset();
        order.delete();
        gap_bad = 0;
        fork
            begin
                bit okl;
                p1_active = 1'b1;
                drive(1, 1, 1, 8'h11, 0, 2'b10);
                wait_done(1, okl);
                drive(1, 1, 1, 8'h22, 0, 2'b10);
                wait_done(1, okl);
                drive(1, 1, 0, 8'h33, 0, 2'b10);
                wait_done(1, okl);
                p1_active = 1'b0;
                drive(1, 0, 0, 8'h00, 0, 2'b00);
            end
            begin
                bit okw;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (bus.gnt1) break;
                end
                drive(0, 1, 0, 8'h44, 0, 2'b01);
                wait_done(0, okw);
                chk("lk_p0_done", okw, 1'b1);
                drive(0, 0, 0, 8'h00, 0, 2'b00);
            end
        join
        repeat (2) @(negedge clk);
        chk("lk_order", order.size(), 4);
        if (order.size() == 4) begin
            chk("lk_seq", {order[0][1:0], order[1][1:0],
                           order[2][1:0], order[3][1:0]}, 8'b01_01_01_00);
        end
        chk("lk_cs_held", lk_hi, 0);
        chk("lk_no_gnt0", ovl, 0);
        chk("lk_cs_gap", gap_bad, 0);

        // Slow mode with a late busy, then an engine that never responds
        do_reset();
        eng_delay = 63;
        eng_rx = 8'h6E;
        drive(1, 1, 0, 8'h77, 1, 2'b01);
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.gnt1 && bus.eng_slow !== 1'b1) lat++;
            if (bus.done1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("slow_done", ok, 1'b1);
        chk("slow_held", lat, 0);
        chk("slow_no_err", bus.err, 1'b0);
        chk("slow_rx", bus.rxdata, 8'h6E);
        @(posedge clk);
        #1;
        drive(1, 0, 0, 8'h00, 0, 2'b00);
        repeat (3) @(negedge clk);

        eng_delay = 2;
        eng_never = 1'b1;
        eng_rx = 8'hAA;
        drive(1, 1, 0, 8'h99, 0, 2'b10);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.eng_txstart) break;
        end
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("to_done", ok, 1'b1);
        chk("to_latency", lat, 81);
        chk("to_err", bus.err, 1'b1);
        chk("to_rx_kept", bus.rxdata, 8'h6E);
        @(posedge clk);
        #1;
        drive(1, 0, 0, 8'h00, 0, 2'b00);
        repeat (4) @(negedge clk);
        chk("to_err_sticky", bus.err, 1'b1);
        eng_never = 1'b0;
        drive(0, 1, 0, 8'h01, 0, 2'b01);
        wait_done(0, ok);
        chk("err_clear_done", ok, 1'b1);
        chk("err_cleared", bus.err, 1'b0);
        chk("err_clear_rx", bus.rxdata, 8'hAA);
        drive(0, 0, 0, 8'h00, 0, 2'b00);
        repeat (3) @(negedge clk);

        // Asynchronous reset while the engine is busy
        eng_len = 20;
        drive(0, 1, 0, 8'h55, 0, 2'b01);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy_m) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ar_busy", ok, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
        chk("ar_ssel_n", bus.spi_ssel_n, 2'b11);
        chk("ar_txstart", bus.eng_txstart, 1'b0);
        drive(0, 0, 0, 8'h00, 0, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        eng_len = 3;
        eng_rx = 8'h5C;
        @(negedge clk);
        drive(0, 1, 0, 8'h56, 0, 2'b10);
        wait_done(0, ok);
        chk("ar_after_done", ok, 1'b1);
        chk("ar_after_rx", bus.rxdata, 8'h5C);
        drive(0, 0, 0, 8'h00, 0, 2'b00);
        repeat (3) @(negedge clk);

`ifdef SPI_ARB_FAIRLOCK_EN
        // Locked stream of 20 bytes is forced to yield after 16
        do_reset();
        order.delete();
        fork
            begin
                bit okf;
                for (int i = 0; i < 20; i++) begin
                    drive(0, 1, (i != 19), 8'(i), 0, 2'b01);
                    wait_done(0, okf);
                    chk("fl_p0_done", okf, 1'b1);
                end
                drive(0, 0, 0, 8'h00, 0, 2'b00);
            end
            begin
                bit okg;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (bus.gnt0) break;
                end
                drive(1, 1, 0, 8'hEE, 0, 2'b10);
                wait_done(1, okg);
                chk("fl_p1_done", okg, 1'b1);
                drive(1, 0, 0, 8'h00, 0, 2'b00);
            end
        join
        repeat (2) @(negedge clk);
        chk("fl_total", order.size(), 21);
        if (order.size() == 21) begin
            chk("fl_p1_slot", order[16], 1);
            chk("fl_p0_before", order[15], 0);
            chk("fl_p0_after", order[17], 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Shares the single SPI byte engine (txdata/txstart/busy/rxdata/slow) between two requesters: port 0 is the CPU register interface, port 1 is the boot/DMA sector loader.
- Arbitrates per transaction, holds chip-select and ownership across multi-byte locked sequences, and sequences the engine's start/busy handshake.
- Returns each completed byte with a one-cycle done pulse.
- Sits between the register file / loader and the SPI byte engine, in the main clock domain.

Parameters:
- NSEL, 2, number of chip-select lines driven.
- START_WAIT, 80, max clk cycles to wait for engine busy to rise after txstart; must be ≥ 64 (slow-mode divider period) + margin.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1  byte transfer request; level, held until done
- lock0, lock1  in  1  keep grant and chip-select after this byte
- txdata0, txdata1  in  8  byte to send
- slow0, slow1  in  1  slow SCK select for this requester
- ssel0, ssel1  in  NSEL  one-hot chip-select wanted by this requester
- gnt0, gnt1  out  1  requester currently owns the engine
- done0, done1  out  1  one-cycle pulse; byte complete, rxdata valid
- rxdata  out  8  last received byte, held until the next done
- eng_txdata  out  8  to engine txdata
- eng_txstart  out  1  to engine txstart; one-cycle pulse
- eng_slow  out  1  to engine slow
- eng_busy  in  1  from engine busy
- eng_rxdata  in  8  from engine rxdata
- spi_ssel_n  out  NSEL  active-low chip selects
- err  out  1  sticky start-timeout flag; cleared by reset or by the next accepted request

Behaviour:
- Reset values: gnt0/1=0, done0/1=0, rxdata=0, eng_txdata=0, eng_txstart=0, eng_slow=0, spi_ssel_n=all 1, err=0, last-winner=1 (so port 0 wins the first tie), state=IDLE.
- State IDLE: no owner, all selects deasserted.
  - Any req → ARB.
- State ARB (1 cycle): pick the owner.
  - One requester active: it wins.
  - Both active: round-robin; the port that did not win last time wins.
  - Set gnt; latch owner's txdata, slow and ssel into eng_txdata, eng_slow, spi_ssel_n (inverted).
  - → START.
- State START: drive eng_txstart=1 for exactly one cycle; clear err; load the start counter. → WAIT_BUSY.
- State WAIT_BUSY: wait for eng_busy=1.
  - busy seen → WAIT_DONE.
  - Counter expires (START_WAIT cycles) → set err, pulse done with rxdata unchanged, → RELEASE.
- State WAIT_DONE: wait for eng_busy=0.
  - Next cycle: rxdata←eng_rxdata; owner's done=1 for one cycle.
  - Owner's lock=1 → HOLD; else → RELEASE.
- State HOLD: gnt and spi_ssel_n held, eng_slow held.
  - Owner req=1 → latch new txdata only (slow/ssel stay frozen until release), → START. The other port is not considered.
  - Owner lock=0 → RELEASE.
- State RELEASE (1 cycle): spi_ssel_n all 1, gnt cleared, last-winner updated. → IDLE.
  - This guarantees ≥1 cycle of CS high between different owners.
- Rules:
  - eng_txdata/eng_slow are stable from ARB through WAIT_DONE. slow never changes while the engine is busy.
  - Done latency: 1 (ARB) + 1 (START) + engine time + 1 cycle after busy falls.
  - Requester must keep req high until its done. Dropping req before done is ignored; the byte completes.
  - Requester must drop req, or present the next byte, on the cycle after done. req still high in HOLD starts a new byte.
  - lock sampled on the done cycle only.
  - Non-owner req while another port is owned: waits, no effect.
- Async reset mid-transfer: all outputs to reset values immediately. The engine is reset by the same rst in the top level.

Optional Feature:
- SPI_ARB_FAIRLOCK_EN defined: a HOLD owner is force-released after 16 consecutive locked bytes if the other port is requesting.
  - The 16th byte completes normally, then → RELEASE regardless of lock.
  - The owner's next request re-arbitrates.
- Undefined: lock is honoured indefinitely; the 5-bit locked-byte counter is absent.

Decomposition:
- Package spi_arb_pkg: state encoding (IDLE, ARB, START, WAIT_BUSY, WAIT_DONE, HOLD, RELEASE), START_WAIT default, locked-byte limit 16.
- One sub-module, spi_arb_rr: 2-way round-robin picker. Inputs req vector and last-winner; outputs one-hot grant.
- FSM, latches and counters stay in the top.

Test Plan:
- Single byte, req0=1, txdata0=8'hA5, slow0=0, ssel0=2'b01, engine model returns 8'h3C → eng_txstart one pulse; spi_ssel_n=2'b10 during transfer; done0 once; rxdata=8'h3C; ssel back to 2'b11.
- req0 and req1 rise the same cycle after reset → port 0 granted first, then port 1. Repeat with both held → grants alternate 0,1,0,1.
- Port 1 lock1=1 for 3 bytes (11,22,33) while req0 held → spi_ssel_n stays low across all 3; gnt0 only after RELEASE; one cycle with all selects high before port 0's byte.
- slow1=1, engine busy delayed 63 cycles → no err; eng_slow stays 1 until done1. Engine never busy → err=1 after START_WAIT cycles; done1 pulse.
- Assert rst_n=0 in WAIT_DONE → gnt=0, spi_ssel_n all 1, eng_txstart=0 immediately. After release, a new request completes normally.
- SPI_ARB_FAIRLOCK_EN: port 0 locked stream of 20 bytes with req1 high → released after byte 16; port 1 byte served; port 0 resumes.
